// File: rtl/vga_pkg.sv
// Shared VGA text-mode definitions: cursor command codes
// and default text geometry.
package vga_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_IDLE   = 3'b000;
    localparam cmd_t CMD_WR_EN  = 3'b001;
    localparam cmd_t CMD_WR_ROW = 3'b010;
    localparam cmd_t CMD_WR_COL = 3'b011;
    localparam cmd_t CMD_ADV    = 3'b100;
    localparam cmd_t CMD_NL     = 3'b101;
    localparam cmd_t CMD_BS     = 3'b110;
    localparam cmd_t CMD_HOME   = 3'b111;

    localparam int VGA_TEXT_ROWS = 60;
    localparam int VGA_TEXT_COLS = 80;

endpackage

// File: rtl/cursor_ctrl_if.sv
// Command bus from the VGA register decoder to the cursor
// controller: one command plus operand per cycle.
interface cursor_ctrl_if #(
    parameter int DW = 8
);
    logic [2:0]    cmd_i;
    logic [DW-1:0] wdata_i;

    modport master (output cmd_i, output wdata_i);
    modport slave  (input  cmd_i, input  wdata_i);
endinterface

// File: rtl/cursor_ctrl_blink_timer.sv
// Cursor blink phase generator; phase is 1 while idle and
// after every restart, toggling each BLINK_HALF cycles of run.
module cursor_blink_timer #(
    parameter int BLINK_HALF = 25000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic restart_i,
    output logic phase_o
);
    localparam int CW = $clog2(BLINK_HALF);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i || !run_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Text-mode cursor controller: position, enable, motion
// commands with wrap, scroll request and blink visibility.
module cursor_ctrl
    import vga_pkg::*;
#(
    parameter int DW         = 8,
    parameter int ROWS       = VGA_TEXT_ROWS,
    parameter int COLS       = VGA_TEXT_COLS,
    parameter int BLINK_HALF = 25000000
) (
    input  logic          clk_i,
    input  logic          reset_i,
    cursor_ctrl_if.slave  bus,
    output logic          c_en_o,
    output logic          c_blink_en_o,
    output logic          c_visible_o,
    output logic [DW-1:0] c_row_o,
    output logic [DW-1:0] c_col_o,
    output logic          scroll_o
);
    localparam logic [DW-1:0] ROW_MAX = DW'(ROWS - 1);
    localparam logic [DW-1:0] COL_MAX = DW'(COLS - 1);

    cmd_t          cmd;
    logic [DW-1:0] wdata;
    logic          en_q, en_d, ben_q, ben_d;
    logic [DW-1:0] row_q, row_d, col_q, col_d;
    logic          scroll_q, scroll_d;
    logic          wr_ok, restart, phase;

    assign cmd   = bus.cmd_i;
    assign wdata = bus.wdata_i;

    always_comb begin
        en_d     = en_q;
        ben_d    = ben_q;
        row_d    = row_q;
        col_d    = col_q;
        scroll_d = 1'b0;
        wr_ok    = 1'b0;
        unique case (1'b1)
            (cmd == CMD_WR_EN): begin
                en_d  = wdata[0];
                ben_d = wdata[1];
            end
            (cmd == CMD_WR_ROW): begin
                if (wdata <= ROW_MAX) begin
                    row_d = wdata;
                    wr_ok = 1'b1;
                end
            end
            (cmd == CMD_WR_COL): begin
                if (wdata <= COL_MAX) begin
                    col_d = wdata;
                    wr_ok = 1'b1;
                end
            end
            (cmd == CMD_ADV), (cmd == CMD_NL): begin
                if (cmd == CMD_NL || col_q == COL_MAX) begin
                    col_d = '0;
                    if (row_q == ROW_MAX) begin
                        row_d    = '0;
                        scroll_d = 1'b1;
                    end else begin
                        row_d = row_q + DW'(1);
                    end
                end else begin
                    col_d = col_q + DW'(1);
                end
            end
            (cmd == CMD_BS): begin
                if (col_q != '0) begin
                    col_d = col_q - DW'(1);
                end else if (row_q != '0) begin
                    col_d = COL_MAX;
                    row_d = row_q - DW'(1);
                end
            end
            (cmd == CMD_HOME): begin
                row_d = '0;
                col_d = '0;
            end
            default: ;
        endcase
        // Keystrokes keep the cursor lit for a full half-period.
        restart = wr_ok | (row_d != row_q) | (col_d != col_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q     <= 1'b0;
            ben_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            scroll_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            ben_q    <= ben_d;
            row_q    <= row_d;
            col_q    <= col_d;
            scroll_q <= scroll_d;
        end
    end

    cursor_blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .run_i    (en_q & ben_q),
        .restart_i(restart),
        .phase_o  (phase)
    );

    assign c_en_o       = en_q;
    assign c_blink_en_o = ben_q;
    assign c_visible_o  = en_q & (phase | ~ben_q);
    assign c_row_o      = row_q;
    assign c_col_o      = col_q;
    assign scroll_o     = scroll_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: directed and random commands against a
// linear-position reference model, plus a default-geometry instance.
module tb_cursor_ctrl;
    localparam int R = 4;
    localparam int C = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2;
    logic       c_en, c_ben, c_vis, scr;
    logic [7:0] c_row, c_col;
    logic       d2_en, d2_ben, d2_vis, d2_scr;
    logic [7:0] d2_row, d2_col;

    cursor_ctrl_if #(.DW(8)) bus ();
    cursor_ctrl_if #(.DW(8)) bus2 ();

    cursor_ctrl #(.DW(8), .ROWS(R), .COLS(C), .BLINK_HALF(H)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus),
        .c_en_o(c_en), .c_blink_en_o(c_ben), .c_visible_o(c_vis),
        .c_row_o(c_row), .c_col_o(c_col), .scroll_o(scr)
    );

    cursor_ctrl dut2 (
        .clk_i(clk), .reset_i(rst2), .bus(bus2),
        .c_en_o(d2_en), .c_blink_en_o(d2_ben), .c_visible_o(d2_vis),
        .c_row_o(d2_row), .c_col_o(d2_col), .scroll_o(d2_scr)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // reference state: position kept as linear index row*C+col
    int m_en, m_ben, m_row, m_col, m_age, m_scr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model(input logic r, input int c, input int d);
        int pos, npos, run, acc;
        if (r) begin
            m_en = 0; m_ben = 0; m_row = 0; m_col = 0;
            m_age = 0; m_scr = 0;
            return;
        end
        run  = m_en & m_ben;
        pos  = m_row * C + m_col;
        npos = pos;
        acc  = 0;
        m_scr = 0;
        case (c)
            1: begin m_en = d & 1; m_ben = (d >> 1) & 1; end
            2: if (d < R) begin npos = d * C + m_col; acc = 1; end
            3: if (d < C) begin npos = m_row * C + d; acc = 1; end
            4: begin npos = (pos + 1) % (R * C); m_scr = (pos == R * C - 1); end
            5: begin npos = ((m_row + 1) % R) * C; m_scr = (m_row == R - 1); end
            6: npos = (pos > 0) ? pos - 1 : 0;
            7: npos = 0;
            default: ;
        endcase
        m_row = npos / C;
        m_col = npos % C;
        m_age = (acc || npos != pos || !run) ? 0 : m_age + 1;
    endtask

    function automatic int exp_vis();
        return (m_en != 0 && (((m_age / H) % 2) == 0 || m_ben == 0)) ? 1 : 0;
    endfunction

    task automatic step(input logic r, input int c, input int d);
        @(negedge clk);
        rst = r;
        bus.cmd_i = 3'(c);
        bus.wdata_i = 8'(d);
        @(posedge clk);
        model(r, c, d);
        #1;
        chk("row", c_row, m_row);
        chk("col", c_col, m_col);
        chk("en", c_en, m_en);
        chk("visible", c_vis, exp_vis());
        chk("scroll", scr, m_scr);
    endtask

    task automatic step2(input logic r, input int c, input int d);
        @(negedge clk);
        rst2 = r;
        bus2.cmd_i = 3'(c);
        bus2.wdata_i = 8'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus.cmd_i = 3'd0; bus.wdata_i = 8'd0;
        bus2.cmd_i = 3'd0; bus2.wdata_i = 8'd0;

        step(1, 0, 0);
        chk("reset_vis", c_vis, 0);

        // reset beats a coincident ADV
        step(0, 2, 2); step(0, 3, 3); step(0, 1, 1);
        chk("pre_rst_en", c_en, 1);
        step(1, 4, 0);
        chk("rst_row", c_row, 0);
        chk("rst_col", c_col, 0);
        chk("rst_en", c_en, 0);

        // range checks
        step(0, 2, 3); chk("wr_row3", c_row, 3);
        step(0, 2, 4); chk("wr_row4_ign", c_row, 3);
        step(0, 3, 5); chk("wr_col5_ign", c_col, 0);
        step(0, 3, 4); chk("wr_col4", c_col, 4);

        // wrap chain
        step(0, 4, 0);
        chk("adv_wrap_row", c_row, 0);
        chk("adv_wrap_scr", scr, 1);
        step(0, 0, 0); chk("scr_one_cycle", scr, 0);
        step(0, 2, 1); step(0, 3, 4); step(0, 4, 0);
        chk("adv_row2", c_row, 2);
        chk("adv_noscr", scr, 0);

        // NL and BS
        step(0, 2, 3); step(0, 3, 2); step(0, 5, 0);
        chk("nl_scr", scr, 1);
        step(0, 2, 2); step(0, 6, 0);
        chk("bs_row", c_row, 1);
        chk("bs_col", c_col, 4);
        step(0, 1, 3); step(0, 7, 0);
        step(0, 0, 0); step(0, 0, 0);
        step(0, 6, 0); step(0, 0, 0);
        chk("bs00_blink_off", c_vis, 0);

        // blink pattern, then ADV restart at cycle 6
        step(0, 1, 0); step(0, 1, 3);
        for (int i = 0; i < 6; i++) begin
            chk("blink_pat", c_vis, ((i / H) % 2 == 0) ? 1 : 0);
            step(0, 0, 0);
        end
        step(0, 4, 0);
        chk("adv_restart", c_vis, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        step(0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0);
            chk("steady", c_vis, 1);
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int c, d;
            c = $urandom_range(0, 7);
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(0, 6);
            if (c == 1 && $urandom_range(0, 2) != 0) d = 3;
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, c, d);
        end

        // default 60x80 geometry
        step2(1, 0, 0);
        step2(0, 2, 59);
        step2(0, 3, 79);
        chk("d2_col79", d2_col, 79);
        step2(0, 4, 0);
        chk("d2_row", d2_row, 0);
        chk("d2_col", d2_col, 0);
        chk("d2_scr", d2_scr, 1);
        step2(0, 3, 80);
        chk("d2_col80_ign", d2_col, 0);
        chk("d2_scr_low", d2_scr, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
